mem_bus_arbiter: RTL and testbench

- Sequences and shares the single main-memory port between the instruction cache, the dcache MSHR load path, and the store-queue retire path.
- Each cycle it picks one requester round-robin and drives the memory command, address and data.
- On memory acceptance it returns the nonzero 4-bit transaction tag to the winner and records which requester owns each outstanding load tag.
- When memory returns a tag with data, it steers the response to the owning requester.

---
 rtl/mem_bus_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single main-memory port between the icache,
// the dcache MSHR load path and the store-queue retire path.
//
// Ports
//   clock_i, reset_ni             clock, asynchronous active-low reset
//   icache_req_*_i                icache load request (held until ack)
//   dcache_req_*_i                dcache load request (held until ack)
//   sq_req_*_i                    store request with 64-bit data (held until ack)
//   mem2arb_response_i            acceptance tag for the current command, 0 = rejected
//   mem2arb_tag_i / _data_i       returning load tag (0 = none) and data
//   arb2mem_command/addr/data_o   command (0 NONE, 1 LOAD, 2 STORE), address, store data
//   *_ack_o, ack_tag_o            same-cycle acceptance and its tag
//   *_resp_valid_o, resp_tag_o,
//   resp_data_o                   returning data steered to the owning requester
//   outstanding_cnt_o             in-flight load count
//   tag_error_o                   sticky: data returned for an unowned tag
//
// Command, ack and response outputs are combinational from the request and
// memory inputs (acceptance is same-cycle) and are forced to 0 while reset
// is asserted.
module mem_bus_arbiter #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic            clock_i,
    input  logic            reset_ni,
    input  logic            icache_req_valid_i,
    input  logic [XLEN-1:0] icache_req_addr_i,
    input  logic            dcache_req_valid_i,
    input  logic [XLEN-1:0] dcache_req_addr_i,
    input  logic            sq_req_valid_i,
    input  logic [XLEN-1:0] sq_req_addr_i,
    input  logic [63:0]     sq_req_data_i,
    input  logic [3:0]      mem2arb_response_i,
    input  logic [3:0]      mem2arb_tag_i,
    input  logic [63:0]     mem2arb_data_i,
    output logic [1:0]      arb2mem_command_o,
    output logic [XLEN-1:0] arb2mem_addr_o,
    output logic [63:0]     arb2mem_data_o,
    output logic            icache_ack_o,
    output logic            dcache_ack_o,
    output logic            sq_ack_o,
    output logic [3:0]      ack_tag_o,
    output logic            icache_resp_valid_o,
    output logic            dcache_resp_valid_o,
    output logic [3:0]      resp_tag_o,
    output logic [63:0]     resp_data_o,
    output logic [3:0]      outstanding_cnt_o,
    output logic            tag_error_o
);

    localparam int unsigned TAG_W    = 4;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_TAGS = 16;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [1:0] {
        REQ_I = 2'd0,
        REQ_D = 2'd1,
        REQ_S = 2'd2
    } req_e;

    // Round-robin successor, mod 3.
    function automatic req_e next_req(input req_e r);
        case (r)
            REQ_I:   next_req = REQ_D;
            REQ_D:   next_req = REQ_S;
            default: next_req = REQ_I;
        endcase
    endfunction

    req_e                rr_q, rr_d;
    logic                lock_valid_q, lock_valid_d;
    req_e                lock_id_q, lock_id_d;
    logic [NUM_TAGS-1:0] own_valid_q, own_valid_d;
    logic [NUM_TAGS-1:0] own_dcache_q, own_dcache_d;
    logic [TAG_W-1:0]    cnt_q, cnt_d;
    logic                tag_err_q, tag_err_d;

    logic                load_room;
    logic [3:0]          req_valid;
    logic [3:0]          elig;
    logic                win_valid;
    req_e                win_id;
    req_e                cand;
    logic [1:0]          cmd_c;
    logic [XLEN-1:0]     addr_c;
    logic [DATA_W-1:0]   data_c;
    logic                accept;
    logic                load_acc;
    logic                ret_hit;
    logic                ret_miss;

    // Winner selection: a held (rejected) requester keeps the bus, otherwise
    // scan from the round-robin pointer. Bit 3 pads the unused encoding.
    always_comb begin
        load_room = cnt_q < TAG_W'(MAX_OUTSTANDING);
        req_valid = {1'b0, sq_req_valid_i, dcache_req_valid_i, icache_req_valid_i};
        elig      = {1'b0, sq_req_valid_i, dcache_req_valid_i & load_room,
                     icache_req_valid_i & load_room};
        win_valid = 1'b0;
        win_id    = REQ_I;
        cand      = rr_q;
        if (lock_valid_q) begin
            // Count is ignored here: the lock was taken while eligible.
            win_id    = lock_id_q;
            win_valid = req_valid[lock_id_q];
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!win_valid && elig[cand]) begin
                    win_valid = 1'b1;
                    win_id    = cand;
                end
                cand = next_req(cand);
            end
        end
    end

    // Memory command drive and same-cycle acceptance.
    always_comb begin
        cmd_c  = CMD_NONE;
        addr_c = '0;
        data_c = '0;
        if (win_valid) begin
            case (win_id)
                REQ_I: begin
                    cmd_c  = CMD_LOAD;
                    addr_c = icache_req_addr_i;
                end
                REQ_D: begin
                    cmd_c  = CMD_LOAD;
                    addr_c = dcache_req_addr_i;
                end
                default: begin
                    cmd_c  = CMD_STORE;
                    addr_c = sq_req_addr_i;
                    data_c = sq_req_data_i;
                end
            endcase
        end
        accept   = win_valid && (mem2arb_response_i != '0);
        load_acc = accept && (win_id != REQ_S);
        ret_hit  = (mem2arb_tag_i != '0) && own_valid_q[mem2arb_tag_i];
        ret_miss = (mem2arb_tag_i != '0) && !own_valid_q[mem2arb_tag_i];
    end

    // Next state: pointer/lock, owner table (new allocation overrides a
    // same-tag return), in-flight count and sticky error.
    always_comb begin
        rr_d         = rr_q;
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        own_valid_d  = own_valid_q;
        own_dcache_d = own_dcache_q;
        tag_err_d    = tag_err_q | ret_miss;

        if (accept) begin
            rr_d         = next_req(win_id);
            lock_valid_d = 1'b0;
        end else if (win_valid) begin
            lock_valid_d = 1'b1;
            lock_id_d    = win_id;
        end else begin
            // Also releases a lock whose requester dropped its valid.
            lock_valid_d = 1'b0;
        end

        if (ret_hit) begin
            own_valid_d[mem2arb_tag_i] = 1'b0;
        end
        if (load_acc) begin
            own_valid_d[mem2arb_response_i]  = 1'b1;
            own_dcache_d[mem2arb_response_i] = (win_id == REQ_D);
        end

        cnt_d = cnt_q + TAG_W'(load_acc) - TAG_W'(ret_hit);
    end

    // State registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_q         <= REQ_I;
            lock_valid_q <= 1'b0;
            lock_id_q    <= REQ_I;
            own_valid_q  <= '0;
            own_dcache_q <= '0;
            cnt_q        <= '0;
            tag_err_q    <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            own_valid_q  <= own_valid_d;
            own_dcache_q <= own_dcache_d;
            cnt_q        <= cnt_d;
            tag_err_q    <= tag_err_d;
        end
    end

    // Outputs; the combinational paths are silenced while reset is low.
    always_comb begin
        arb2mem_command_o   = reset_ni ? cmd_c : CMD_NONE;
        arb2mem_addr_o      = reset_ni ? addr_c : '0;
        arb2mem_data_o      = reset_ni ? data_c : '0;
        icache_ack_o        = reset_ni && accept && (win_id == REQ_I);
        dcache_ack_o        = reset_ni && accept && (win_id == REQ_D);
        sq_ack_o            = reset_ni && accept && (win_id == REQ_S);
        ack_tag_o           = (reset_ni && accept) ? mem2arb_response_i : '0;
        icache_resp_valid_o = reset_ni && ret_hit && !own_dcache_q[mem2arb_tag_i];
        dcache_resp_valid_o = reset_ni && ret_hit && own_dcache_q[mem2arb_tag_i];
        resp_tag_o          = reset_ni ? mem2arb_tag_i : '0;
        resp_data_o         = reset_ni ? mem2arb_data_i : '0;
        outstanding_cnt_o   = cnt_q;
        tag_error_o         = tag_err_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by randomized
// traffic, checked through a scoreboard against a transaction-level model
// (pending requests, a tag->owner map, a round-robin pointer).
module tb_mem_bus_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned MAXO = 3;

    logic            clk = 1'b0;
    logic            reset_ni;
    logic            icache_req_valid_i, dcache_req_valid_i, sq_req_valid_i;
    logic [XLEN-1:0] icache_req_addr_i, dcache_req_addr_i, sq_req_addr_i;
    logic [63:0]     sq_req_data_i;
    logic [3:0]      mem2arb_response_i, mem2arb_tag_i;
    logic [63:0]     mem2arb_data_i;
    logic [1:0]      arb2mem_command_o;
    logic [XLEN-1:0] arb2mem_addr_o;
    logic [63:0]     arb2mem_data_o;
    logic            icache_ack_o, dcache_ack_o, sq_ack_o;
    logic [3:0]      ack_tag_o;
    logic            icache_resp_valid_o, dcache_resp_valid_o;
    logic [3:0]      resp_tag_o;
    logic [63:0]     resp_data_o;
    logic [3:0]      outstanding_cnt_o;
    logic            tag_error_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
        .clock_i             (clk),
        .reset_ni            (reset_ni),
        .icache_req_valid_i  (icache_req_valid_i),
        .icache_req_addr_i   (icache_req_addr_i),
        .dcache_req_valid_i  (dcache_req_valid_i),
        .dcache_req_addr_i   (dcache_req_addr_i),
        .sq_req_valid_i      (sq_req_valid_i),
        .sq_req_addr_i       (sq_req_addr_i),
        .sq_req_data_i       (sq_req_data_i),
        .mem2arb_response_i  (mem2arb_response_i),
        .mem2arb_tag_i       (mem2arb_tag_i),
        .mem2arb_data_i      (mem2arb_data_i),
        .arb2mem_command_o   (arb2mem_command_o),
        .arb2mem_addr_o      (arb2mem_addr_o),
        .arb2mem_data_o      (arb2mem_data_o),
        .icache_ack_o        (icache_ack_o),
        .dcache_ack_o        (dcache_ack_o),
        .sq_ack_o            (sq_ack_o),
        .ack_tag_o           (ack_tag_o),
        .icache_resp_valid_o (icache_resp_valid_o),
        .dcache_resp_valid_o (dcache_resp_valid_o),
        .resp_tag_o          (resp_tag_o),
        .resp_data_o         (resp_data_o),
        .outstanding_cnt_o   (outstanding_cnt_o),
        .tag_error_o         (tag_error_o)
    );

    typedef struct {
        logic [1:0]      cmd;
        logic [XLEN-1:0] addr;
        logic [63:0]     data;
        logic [3:0]      cnt;
        logic            err;
    } st_t;
    typedef struct { int who; logic [3:0] tag; } ack_t;
    typedef struct { int who; logic [3:0] tag; logic [63:0] data; } rsp_t;

    st_t  st_q[$];
    ack_t ack_q[$];
    rsp_t rsp_q[$];

    // Reference model state. Requesters: 0 icache, 1 dcache, 2 store queue.
    int              rr;
    int              held;
    int              owner[int];
    bit              err;
    bit              req_v[3];
    logic [XLEN-1:0] req_a[3];
    logic [63:0]     sq_d;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tagname);
        chk({tagname, "_cmd"},  64'(arb2mem_command_o), 64'd0);
        chk({tagname, "_addr"}, 64'(arb2mem_addr_o), 64'd0);
        chk({tagname, "_data"}, arb2mem_data_o, 64'd0);
        chk({tagname, "_acks"}, 64'({icache_ack_o, dcache_ack_o, sq_ack_o}), 64'd0);
        chk({tagname, "_ack_tag"}, 64'(ack_tag_o), 64'd0);
        chk({tagname, "_rvalid"}, 64'({icache_resp_valid_o, dcache_resp_valid_o}), 64'd0);
        chk({tagname, "_rtag"}, 64'(resp_tag_o), 64'd0);
        chk({tagname, "_rdata"}, resp_data_o, 64'd0);
        chk({tagname, "_cnt"}, 64'(outstanding_cnt_o), 64'd0);
        chk({tagname, "_err"}, 64'(tag_error_o), 64'd0);
    endtask

    function automatic int pick();
        if (held >= 0) return held;
        for (int k = 0; k < 3; k++) begin
            int id;
            id = (rr + k) % 3;
            if (req_v[id] && (id == 2 || owner.num() < int'(MAXO))) return id;
        end
        return -1;
    endfunction

    // One clock cycle of stimulus. resp_sel: -1 random, else the response
    // value. ret_sel: -1 random owned tag (or none), else the return tag.
    task automatic step(input int resp_sel, input int ret_sel, input logic [63:0] rdata_in);
        int          w, rsp, ret;
        int          keys[$];
        int          tq[$];
        logic [63:0] rdata;
        st_t         s;
        ack_t        a;
        rsp_t        r;
        @(posedge clk);
        #1;
        rdata = rdata_in;
        if (ret_sel < 0) begin
            ret = 0;
            rdata = {$urandom, $urandom};
            if (owner.num() > 0 && $urandom_range(0, 99) < 30) begin
                foreach (owner[k]) keys.push_back(k);
                ret = keys[$urandom_range(0, keys.size() - 1)];
            end
        end else begin
            ret = ret_sel;
        end
        w = pick();
        if (resp_sel >= 0) begin
            rsp = resp_sel;
        end else if (w < 0) begin
            rsp = $urandom_range(0, 15);
        end else if ($urandom_range(0, 99) < 75) begin
            for (int t = 1; t < 16; t++)
                if (!owner.exists(t) || t == ret) tq.push_back(t);
            rsp = tq[$urandom_range(0, tq.size() - 1)];
        end else begin
            rsp = 0;
        end

        icache_req_valid_i = req_v[0];
        icache_req_addr_i  = req_a[0];
        dcache_req_valid_i = req_v[1];
        dcache_req_addr_i  = req_a[1];
        sq_req_valid_i     = req_v[2];
        sq_req_addr_i      = req_a[2];
        sq_req_data_i      = sq_d;
        mem2arb_response_i = 4'(rsp);
        mem2arb_tag_i      = 4'(ret);
        mem2arb_data_i     = rdata;

        s.cmd  = (w < 0) ? 2'd0 : (w == 2) ? 2'd2 : 2'd1;
        s.addr = (w < 0) ? '0 : req_a[w];
        s.data = (w == 2) ? sq_d : 64'd0;
        s.cnt  = 4'(owner.num());
        s.err  = err;
        st_q.push_back(s);
        if (w >= 0 && rsp != 0) begin
            a.who = w;
            a.tag = 4'(rsp);
            ack_q.push_back(a);
        end
        if (ret != 0) begin
            if (owner.exists(ret)) begin
                r.who  = owner[ret];
                r.tag  = 4'(ret);
                r.data = rdata;
                rsp_q.push_back(r);
                owner.delete(ret);
            end else begin
                err = 1'b1;
            end
        end
        if (w >= 0) begin
            if (rsp != 0) begin
                rr       = (w + 1) % 3;
                held     = -1;
                req_v[w] = 1'b0;
                if (w != 2) owner[rsp] = w;
            end else begin
                held = w;
            end
        end
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < 3; i++) begin
            if (!req_v[i] && $urandom_range(0, 99) < 40) begin
                req_v[i] = 1'b1;
                req_a[i] = $urandom;
                if (i == 2) sq_d = {$urandom, $urandom};
            end
        end
    endtask

    task automatic set_req(input int id, input logic [XLEN-1:0] addr);
        req_v[id] = 1'b1;
        req_a[id] = addr;
    endtask

    task automatic clear_pins();
        icache_req_valid_i = 1'b0; icache_req_addr_i = '0;
        dcache_req_valid_i = 1'b0; dcache_req_addr_i = '0;
        sq_req_valid_i     = 1'b0; sq_req_addr_i     = '0;
        sq_req_data_i      = '0;
        mem2arb_response_i = '0;   mem2arb_tag_i     = '0;
        mem2arb_data_i     = '0;
    endtask

    task automatic model_reset();
        rr = 0;
        held = -1;
        owner.delete();
        err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 1'b0;
            req_a[i] = '0;
        end
        sq_d = '0;
    endtask

    // Monitor: every cycle pops the expected bus state; pops ack/response
    // expectations whenever the DUT presents an ack or a response.
    task automatic check_cycle();
        st_t  s;
        ack_t a;
        rsp_t r;
        if (st_q.size() == 0) begin
            chk("state_queue_underflow", 64'd0, 64'd1);
        end else begin
            s = st_q.pop_front();
            chk("command", 64'(arb2mem_command_o), 64'(s.cmd));
            chk("addr", 64'(arb2mem_addr_o), 64'(s.addr));
            chk("wdata", arb2mem_data_o, s.data);
            chk("outstanding_cnt", 64'(outstanding_cnt_o), 64'(s.cnt));
            chk("tag_error", 64'(tag_error_o), 64'(s.err));
        end
        if (icache_ack_o || dcache_ack_o || sq_ack_o) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", 64'({sq_ack_o, dcache_ack_o, icache_ack_o}), 64'd0);
            end else begin
                a = ack_q.pop_front();
                chk("ack_who", 64'({sq_ack_o, dcache_ack_o, icache_ack_o}), 64'd1 << a.who);
                chk("ack_tag", 64'(ack_tag_o), 64'(a.tag));
            end
        end else begin
            chk("ack_tag_idle", 64'(ack_tag_o), 64'd0);
        end
        if (icache_resp_valid_o || dcache_resp_valid_o) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_resp", 64'({dcache_resp_valid_o, icache_resp_valid_o}), 64'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("resp_who", 64'({dcache_resp_valid_o, icache_resp_valid_o}), 64'd1 << r.who);
                chk("resp_tag", 64'(resp_tag_o), 64'(r.tag));
                chk("resp_data", resp_data_o, r.data);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_ni) check_cycle();
        end
    end

    initial begin
        int keys[$];
        reset_ni = 1'b0;
        clear_pins();
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        #1 reset_ni = 1'b1;

        // Round-robin from pointer 0: icache, dcache, store.
        set_req(0, 32'h200); set_req(1, 32'h300); set_req(2, 32'h400);
        sq_d = 64'h0123_4567_89AB_CDEF;
        step(1, 0, '0); step(2, 0, '0); step(3, 0, '0);
        step(0, 1, 64'h1111_0000_1111_0000);
        step(0, 2, 64'h2222_0000_2222_0000);

        // Single icache load and its return.
        set_req(0, 32'h100);
        step(3, 0, '0);
        step(0, 3, 64'hDEADBEEF_CAFEF00D);

        // Rejection lock: dcache held for two rejects while icache waits.
        set_req(1, 32'h500);
        step(0, 0, '0);
        set_req(0, 32'h600);
        step(0, 0, '0);
        step(5, 0, '0);
        step(6, 0, '0);

        // Throttle at the load cap: only the store can issue.
        set_req(1, 32'h700);
        step(1, 0, '0);
        set_req(0, 32'h800); set_req(2, 32'h900);
        sq_d = 64'hFEED_FACE_0000_0001;
        step(4, 0, '0);
        step(0, 5, 64'h5555_5555_5555_5555);
        step(8, 0, '0);
        step(0, 6, 64'h6);
        step(0, 1, 64'h1);
        step(0, 8, 64'h8);

        // Collision: tag 7 returns to dcache while reallocated to icache.
        set_req(1, 32'hA00);
        step(7, 0, '0);
        set_req(0, 32'hB00);
        step(7, 7, 64'h7777_AAAA_7777_AAAA);
        step(0, 7, 64'h7777_BBBB_7777_BBBB);

        // Unowned return sets the sticky error.
        step(0, 9, 64'h9);
        set_req(0, 32'hC00);
        step(10, 0, '0);
        step(0, 0, '0);

        // Reset mid-cycle with live traffic on the inputs.
        @(posedge clk);
        #1;
        sq_req_valid_i     = 1'b1;
        sq_req_addr_i      = 32'hD00;
        sq_req_data_i      = 64'hABCD;
        mem2arb_response_i = 4'd4;
        mem2arb_tag_i      = 4'd10;
        mem2arb_data_i     = 64'h10;
        #2 reset_ni = 1'b0;
        #1 chk_zero("midreset");
        clear_pins();
        model_reset();
        @(negedge clk);
        #1 reset_ni = 1'b1;

        // Stale tag from before reset.
        step(0, 10, 64'hA);
        step(0, 0, '0);

        // Randomized traffic.
        repeat (1500) begin
            rand_reqs();
            step(-1, -1, '0);
        end

        // Drain: stop new requests, let pending ones finish, return all tags.
        for (int n = 0; n < 200 && (held >= 0 || req_v[0] || req_v[1] || req_v[2]); n++)
            step(-1, 0, '0);
        for (int n = 0; n < 40 && owner.num() > 0; n++) begin
            keys.delete();
            foreach (owner[k]) keys.push_back(k);
            step(0, keys[0], {$urandom, $urandom});
        end
        step(0, 0, '0);
        @(negedge clk);
        #1;
        chk("drain_owner_map_empty", 64'(owner.num()), 64'd0);
        chk("final_cnt", 64'(outstanding_cnt_o), 64'd0);
        chk("leftover_state_q", 64'(st_q.size()), 64'd0);
        chk("leftover_ack_q", 64'(ack_q.size()), 64'd0);
        chk("leftover_resp_q", 64'(rsp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
